readout_arbiter: RTL and testbench

//  Shares the FTDI upstream byte path between the two readout sources: the SPI readout FIFO
//  (64-bit hit words) and the SR readback FIFO (64-bit config words).
//  - Pops whole words from first-word-fall-through (FWFT) FIFOs.
//  - Serialises each word into a framed byte stream (header + 8 data bytes) for the ftdi_top TX path.
//  - Arbitration is round-robin with a per-source burst limit. A frame is never interrupted.

---
 rtl/readout_arbiter_pkg.sv | 25 ++
 rtl/readout_arbiter_if.sv | 31 +++
 rtl/readout_serializer.sv | 108 ++++++++++
 rtl/readout_arbiter.sv | 92 +++++++++
 tb/tb_readout_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/readout_arbiter_pkg.sv
// Shared readout definitions: serializer state encoding, source IDs, default header bytes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package astropix_readout_pkg;

   // Frame phases. TRL exists only in builds that define READOUT_TRAILER_EN.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_DATA = 2'd2,
      ST_TRL  = 2'd3
   } state_t;

   localparam logic SRC_SPI = 1'b0;
   localparam logic SRC_SR  = 1'b1;

   localparam logic [7:0] HDR_SPI_DEF = 8'hA1;
   localparam logic [7:0] HDR_SR_DEF  = 8'hA2;

   // grant bit 0 = SPI, bit 1 = SR
   function automatic logic [1:0] src_onehot(input logic src);
      return (src == SRC_SR) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/readout_arbiter_if.sv
// Readout arbiter bus: two FWFT FIFO read ports, FTDI TX byte handshake, status.
// Latency: n/a (wiring only).
// Backpressure: tx_valid/tx_ready on the byte side; rd_en pops on the FIFO side.
// master = arbiter side, slave = FIFO/FTDI environment side.
interface readout_arbiter_if #(
   parameter int DATA_W = 64
);
   logic              arb_en;
   logic [DATA_W-1:0] spi_fifo_dout;
   logic              spi_fifo_empty;
   logic              spi_fifo_rd_en;
   logic [DATA_W-1:0] sr_fifo_dout;
   logic              sr_fifo_empty;
   logic              sr_fifo_rd_en;
   logic [7:0]        tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic [1:0]        grant;
   logic              busy;

   modport master (
      input  arb_en, spi_fifo_dout, spi_fifo_empty, sr_fifo_dout, sr_fifo_empty, tx_ready,
      output spi_fifo_rd_en, sr_fifo_rd_en, tx_data, tx_valid, grant, busy
   );

   modport slave (
      output arb_en, spi_fifo_dout, spi_fifo_empty, sr_fifo_dout, sr_fifo_empty, tx_ready,
      input  spi_fifo_rd_en, sr_fifo_rd_en, tx_data, tx_valid, grant, busy
   );

endinterface

// File: rtl/readout_serializer.sv
// Serializes one latched word into header + DATA_W/8 bytes MSB first (+ XOR trailer with READOUT_TRAILER_EN).
// Latency: header valid the cycle after i_load; 1+BYTES (2+BYTES with trailer) cycles per frame at full rate.
// Backpressure: each byte held stable on o_tx_valid until i_tx_ready; nothing dropped.
// Ports: clk/res_n; i_load/i_word/i_hdr start a frame (only honoured in IDLE);
//        o_tx_data/o_tx_valid/i_tx_ready byte handshake; o_busy = frame active; o_done = last byte accepted.
module readout_serializer
   import astropix_readout_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              res_n,
   input  logic              i_load,
   input  logic [DATA_W-1:0] i_word,
   input  logic [7:0]        i_hdr,
   input  logic              i_tx_ready,
   output logic [7:0]        o_tx_data,
   output logic              o_tx_valid,
   output logic              o_busy,
   output logic              o_done
);

   localparam int BYTES = DATA_W / 8;
   localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [DATA_W-1:0] r_shift;
   logic [7:0]        r_hdr;
   logic [IDX_W-1:0]  r_idx;
   logic              w_last;
`ifdef READOUT_TRAILER_EN
   logic [7:0]        r_xor;
`endif

   assign w_last = (r_idx == IDX_W'(BYTES - 1));
   assign o_busy = (r_state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (!res_n) begin
         r_state <= ST_IDLE;
         r_shift <= '0;
         r_hdr   <= '0;
         r_idx   <= '0;
`ifdef READOUT_TRAILER_EN
         r_xor   <= '0;
`endif
      end else begin
         r_state <= w_state_nxt;
         if (i_load && (r_state == ST_IDLE)) begin
            r_shift <= i_word;
            r_hdr   <= i_hdr;
            r_idx   <= '0;
`ifdef READOUT_TRAILER_EN
            r_xor   <= i_hdr;
`endif
         end else if ((r_state == ST_DATA) && i_tx_ready) begin
            // Current byte always sits in the top lane; shift the next one up on accept.
            r_shift <= {r_shift[DATA_W-9:0], 8'h00};
            r_idx   <= r_idx + 1'b1;
`ifdef READOUT_TRAILER_EN
            r_xor   <= r_xor ^ r_shift[DATA_W-1 -: 8];
`endif
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      o_tx_valid  = 1'b0;
      o_tx_data   = 8'h00;
      o_done      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_load) w_state_nxt = ST_HDR;
         end
         ST_HDR: begin
            o_tx_valid = 1'b1;
            o_tx_data  = r_hdr;
            if (i_tx_ready) w_state_nxt = ST_DATA;
         end
         ST_DATA: begin
            o_tx_valid = 1'b1;
            o_tx_data  = r_shift[DATA_W-1 -: 8];
            if (i_tx_ready && w_last) begin
`ifdef READOUT_TRAILER_EN
               w_state_nxt = ST_TRL;
`else
               w_state_nxt = ST_IDLE;
               o_done      = 1'b1;
`endif
            end
         end
`ifdef READOUT_TRAILER_EN
         ST_TRL: begin
            o_tx_valid = 1'b1;
            o_tx_data  = r_xor;
            if (i_tx_ready) begin
               w_state_nxt = ST_IDLE;
               o_done      = 1'b1;
            end
         end
`endif
         default: w_state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: rtl/readout_arbiter.sv
// Round-robin (burst-limited) arbiter popping SPI/SR FWFT FIFOs into framed FTDI byte stream.
// Latency: pop decided combinationally in IDLE, header the next cycle; one IDLE cycle between frames.
// Backpressure: tx_ready stalls the running frame in place; frames never interleave; arb_en only gates new frames.
// Ports: clk, res_n (sync, active low); bus (readout_arbiter_if.master): arb_en, SPI/SR FIFO
//        dout/empty/rd_en, tx_data/tx_valid/tx_ready, grant (one-hot [0]=SPI [1]=SR), busy.
// Build option: READOUT_TRAILER_EN adds an XOR trailer byte per frame (handled in readout_serializer).
module readout_arbiter
   import astropix_readout_pkg::*;
#(
   parameter int         DATA_W    = 64,
   parameter int         BURST_LEN = 4,
   parameter logic [7:0] HDR_SPI   = HDR_SPI_DEF,
   parameter logic [7:0] HDR_SR    = HDR_SR_DEF
) (
   input  logic               clk,
   input  logic               res_n,
   readout_arbiter_if.master  bus
);

   localparam int CNT_W = $clog2(BURST_LEN + 1);

   logic              r_ptr;      // last granted source
   logic [CNT_W-1:0]  r_burst;    // consecutive frames from r_ptr, saturating
   logic [1:0]        r_grant;
   logic              w_spi_av;
   logic              w_sr_av;
   logic              w_sel;
   logic              w_start;
   logic              w_ser_busy;
   logic              w_ser_done;
   logic [DATA_W-1:0] w_word;
   logic [7:0]        w_hdr;

   assign w_spi_av = !bus.spi_fifo_empty;
   assign w_sr_av  = !bus.sr_fifo_empty;

   always_comb begin
      w_sel = r_ptr;
      if (w_spi_av && w_sr_av) begin
         // Hand over only once the owner has used up its burst while the other side waits.
         w_sel = (r_burst == CNT_W'(BURST_LEN)) ? ~r_ptr : r_ptr;
      end else if (w_sr_av) begin
         w_sel = SRC_SR;
      end else begin
         w_sel = SRC_SPI;
      end
   end

   assign w_start = res_n && bus.arb_en && !w_ser_busy && (w_spi_av || w_sr_av);

   assign bus.spi_fifo_rd_en = w_start && (w_sel == SRC_SPI);
   assign bus.sr_fifo_rd_en  = w_start && (w_sel == SRC_SR);

   assign w_word = (w_sel == SRC_SR) ? bus.sr_fifo_dout : bus.spi_fifo_dout;
   assign w_hdr  = (w_sel == SRC_SR) ? HDR_SR : HDR_SPI;

   always_ff @(posedge clk) begin
      if (!res_n) begin
         r_ptr   <= SRC_SPI;
         r_burst <= '0;
         r_grant <= 2'b00;
      end else if (w_start) begin
         r_ptr   <= w_sel;
         r_grant <= src_onehot(w_sel);
         if (w_sel != r_ptr)
            r_burst <= CNT_W'(1);
         else if (r_burst != CNT_W'(BURST_LEN))
            r_burst <= r_burst + 1'b1;
      end else if (w_ser_done) begin
         r_grant <= 2'b00;
      end
   end

   readout_serializer #(
      .DATA_W (DATA_W)
   ) u_ser (
      .clk        (clk),
      .res_n      (res_n),
      .i_load     (w_start),
      .i_word     (w_word),
      .i_hdr      (w_hdr),
      .i_tx_ready (bus.tx_ready),
      .o_tx_data  (bus.tx_data),
      .o_tx_valid (bus.tx_valid),
      .o_busy     (w_ser_busy),
      .o_done     (w_ser_done)
   );

   assign bus.grant = r_grant;
   assign bus.busy  = w_ser_busy;

endmodule

// File: tb/tb_readout_arbiter.sv
// Directed bench for readout_arbiter: FWFT FIFO models, byte/pop monitor, one task per scenario.
// Latency: n/a.
// Backpressure: bench drives tx_ready patterns, including toggling.
module tb_readout_arbiter;

`ifdef READOUT_TRAILER_EN
   localparam int FB = 10;
`else
   localparam int FB = 9;
`endif

   logic clk = 1'b0;
   logic res_n = 1'b0;
   always #5 clk = ~clk;

   readout_arbiter_if #(.DATA_W(64)) bus ();

   readout_arbiter #(
      .DATA_W    (64),
      .BURST_LEN (4),
      .HDR_SPI   (8'hA1),
      .HDR_SR    (8'hA2)
   ) dut (
      .clk   (clk),
      .res_n (res_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // FWFT FIFO models: words are kept, a read index marks the head
   logic [63:0] spi_q[$];
   logic [63:0] sr_q[$];
   int spi_rd = 0;
   int sr_rd = 0;
   logic m_spi, m_sr;

   always @(posedge clk) begin
      m_spi = bus.spi_fifo_rd_en;
      m_sr  = bus.sr_fifo_rd_en;
      #2;
      if (m_spi) spi_rd++;
      if (m_sr) sr_rd++;
      bus.spi_fifo_empty = (spi_rd >= spi_q.size());
      bus.spi_fifo_dout  = (spi_rd < spi_q.size()) ? spi_q[spi_rd] : 64'h0;
      bus.sr_fifo_empty  = (sr_rd >= sr_q.size());
      bus.sr_fifo_dout   = (sr_rd < sr_q.size()) ? sr_q[sr_rd] : 64'h0;
   end

   // Monitor: bytes that transfer at the coming posedge, pops, stall stability
   logic [7:0] got_q[$];
   logic [1:0] gnt_q[$];
   int pop_src_q[$];
   int stall_err = 0;
   int stall_cyc = 0;
   int empty_pop_err = 0;
   logic stalled_prev = 1'b0;
   logic [7:0] stalled_byte = 8'h00;

   always @(negedge clk) begin
      if (res_n) begin
         if (bus.tx_valid && bus.tx_ready) begin
            got_q.push_back(bus.tx_data);
            gnt_q.push_back(bus.grant);
         end
         if (bus.spi_fifo_rd_en) begin
            pop_src_q.push_back(0);
            if (bus.spi_fifo_empty) empty_pop_err++;
         end
         if (bus.sr_fifo_rd_en) begin
            pop_src_q.push_back(1);
            if (bus.sr_fifo_empty) empty_pop_err++;
         end
         if (stalled_prev && (!bus.tx_valid || bus.tx_data !== stalled_byte)) stall_err++;
         if (bus.tx_valid && !bus.tx_ready) stall_cyc++;
         stalled_prev = bus.tx_valid && !bus.tx_ready;
         stalled_byte = bus.tx_data;
      end else begin
         stalled_prev = 1'b0;
      end
   end

   logic [7:0] e1 [10] = '{8'hA1, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'hA1};
   logic [7:0] e0 [10] = '{8'hA2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA2};
   logic [7:0] exp_q[$];

   function automatic void exp_frame(input logic [7:0] h, input logic [63:0] w);
      logic [7:0] x;
      x = h;
      exp_q.push_back(h);
      for (int i = 7; i >= 0; i--) begin
         exp_q.push_back(w[i*8 +: 8]);
         x = x ^ w[i*8 +: 8];
      end
`ifdef READOUT_TRAILER_EN
      exp_q.push_back(x);
`endif
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic nedge();
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      res_n = 1'b0;
      bus.arb_en = 1'b0;
      bus.tx_ready = 1'b0;
      repeat (3) step();
      nedge();
      checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid got %b exp 0", bus.tx_valid); end
      checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data got %h exp 00", bus.tx_data); end
      checks++; if (bus.grant !== 2'b00) begin errors++; $display("FAIL rst_grant got %b exp 00", bus.grant); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
      checks++; if ({bus.spi_fifo_rd_en, bus.sr_fifo_rd_en} !== 2'b00) begin errors++; $display("FAIL rst_rd_en got %b exp 00", {bus.spi_fifo_rd_en, bus.sr_fifo_rd_en}); end
      step();
      res_n = 1'b1;
      step();
   endtask

   // Both FIFOs hold 6 words: SPI x4, SR x4, SPI x2, SR x2, one IDLE cycle between frames
   task automatic test_back_to_back();
      int b = got_q.size();
      int pb = pop_src_q.size();
      int s0 = spi_rd;
      int r0 = sr_rd;
      int order[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};
      logic [63:0] sw[6];
      logic [63:0] rw[6];
      int si = 0;
      int ri = 0;
      int cnt = 0;
      int bad_gnt = 0;
      for (int i = 0; i < 6; i++) begin
         sw[i] = 64'hC0DE_0000_0000_0000 + 64'(i) * 64'h0101;
         rw[i] = 64'h5EED_0000_0000_0000 + 64'(i);
         spi_q.push_back(sw[i]);
         sr_q.push_back(rw[i]);
      end
      exp_q.delete();
      for (int k = 0; k < 12; k++) begin
         if (order[k] == 0) begin exp_frame(8'hA1, sw[si]); si++; end
         else begin exp_frame(8'hA2, rw[ri]); ri++; end
      end
      bus.tx_ready = 1'b1;
      bus.arb_en = 1'b1;
      while (!(bus.spi_fifo_rd_en || bus.sr_fifo_rd_en) && cnt < 50) begin nedge(); cnt++; end
      checks++; if (cnt >= 50) begin errors++; $display("FAIL b2b_start_timeout got no rd_en in %0d cycles", cnt); end
      cnt = 1;
      while (got_q.size() < b + 12 * FB && cnt < 1000) begin nedge(); cnt++; end
      checks++; if (cnt !== 12 * (FB + 1)) begin errors++; $display("FAIL b2b_cycles got %0d exp %0d", cnt, 12 * (FB + 1)); end
      repeat (3) nedge();
      checks++; if (spi_rd - s0 !== 6) begin errors++; $display("FAIL b2b_spi_pops got %0d exp 6", spi_rd - s0); end
      checks++; if (sr_rd - r0 !== 6) begin errors++; $display("FAIL b2b_sr_pops got %0d exp 6", sr_rd - r0); end
      checks++; if (pop_src_q.size() - pb !== 12) begin errors++; $display("FAIL b2b_pop_count got %0d exp 12", pop_src_q.size() - pb); end
      for (int k = 0; k < 12; k++) begin
         checks++;
         if (pop_src_q[pb+k] !== order[k]) begin errors++; $display("FAIL b2b_order frame %0d got src %0d exp %0d", k, pop_src_q[pb+k], order[k]); end
      end
      for (int i = 0; i < 12 * FB; i++) begin
         checks++;
         if (got_q[b+i] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte %0d got %h exp %h", i, got_q[b+i], exp_q[i]); end
      end
      for (int k = 0; k < 12; k++)
         for (int j = 0; j < FB; j++)
            if (gnt_q[b+k*FB+j] !== ((order[k] == 0) ? 2'b01 : 2'b10)) bad_gnt++;
      checks++; if (bad_gnt !== 0) begin errors++; $display("FAIL b2b_grant got %0d wrong-grant bytes exp 0", bad_gnt); end
   endtask

   // Single SPI word, SR empty, tx_ready=1
   task automatic test_single();
      int b = got_q.size();
      int s0 = spi_rd;
      int r0 = sr_rd;
      int cnt = 0;
      int bad_gnt = 0;
      bus.tx_ready = 1'b1;
      bus.arb_en = 1'b1;
      spi_q.push_back(64'h0123456789ABCDEF);
      while (!bus.spi_fifo_rd_en && cnt < 50) begin nedge(); cnt++; end
      checks++; if (cnt >= 50) begin errors++; $display("FAIL single_pop_timeout got no spi rd_en in %0d cycles", cnt); end
      nedge();
      checks++; if ({bus.tx_valid, bus.tx_data} !== {1'b1, 8'hA1}) begin errors++; $display("FAIL single_hdr_latency got valid %b data %h exp 1 a1", bus.tx_valid, bus.tx_data); end
      checks++; if (bus.grant !== 2'b01) begin errors++; $display("FAIL single_grant got %b exp 01", bus.grant); end
      cnt = 0;
      while (got_q.size() < b + FB && cnt < 200) begin nedge(); cnt++; end
      nedge();
      checks++; if ({bus.busy, bus.grant} !== 3'b000) begin errors++; $display("FAIL single_end got busy %b grant %b exp 0 00", bus.busy, bus.grant); end
      repeat (3) nedge();
      checks++; if (spi_rd - s0 !== 1) begin errors++; $display("FAIL single_spi_pops got %0d exp 1", spi_rd - s0); end
      checks++; if (sr_rd - r0 !== 0) begin errors++; $display("FAIL single_sr_pops got %0d exp 0", sr_rd - r0); end
      checks++; if (got_q.size() - b !== FB) begin errors++; $display("FAIL single_len got %0d exp %0d", got_q.size() - b, FB); end
      for (int i = 0; i < FB; i++) begin
         checks++;
         if (got_q[b+i] !== e1[i]) begin errors++; $display("FAIL single_byte %0d got %h exp %h", i, got_q[b+i], e1[i]); end
         if (gnt_q[b+i] !== 2'b01) bad_gnt++;
      end
      checks++; if (bad_gnt !== 0) begin errors++; $display("FAIL single_grant_frame got %0d wrong bytes exp 0", bad_gnt); end
   endtask

   // Same frame with tx_ready toggling every cycle
   task automatic test_ready_toggle();
      int b = got_q.size();
      int se = stall_err;
      int sc = stall_cyc;
      int cnt = 0;
      bus.tx_ready = 1'b0;
      spi_q.push_back(64'h0123456789ABCDEF);
      while (got_q.size() < b + FB && cnt < 300) begin
         step();
         bus.tx_ready = ~bus.tx_ready;
         cnt++;
      end
      bus.tx_ready = 1'b1;
      repeat (4) nedge();
      checks++; if (got_q.size() - b !== FB) begin errors++; $display("FAIL toggle_len got %0d exp %0d", got_q.size() - b, FB); end
      for (int i = 0; i < FB; i++) begin
         checks++;
         if (got_q[b+i] !== e1[i]) begin errors++; $display("FAIL toggle_byte %0d got %h exp %h", i, got_q[b+i], e1[i]); end
      end
      checks++; if (stall_err - se !== 0) begin errors++; $display("FAIL toggle_stable got %0d unstable stalls exp 0", stall_err - se); end
      checks++; if (!(stall_cyc - sc > 0)) begin errors++; $display("FAIL toggle_stalls got %0d stall cycles exp >0", stall_cyc - sc); end
   endtask

   // Reset after the 3rd data byte of an SR frame; pointer returns to SPI, aborted word gone
   task automatic test_mid_reset();
      int b = got_q.size();
      int b2;
      int s0 = spi_rd;
      int r0 = sr_rd;
      int cnt = 0;
      bus.tx_ready = 1'b1;
      bus.arb_en = 1'b1;
      sr_q.push_back(64'hDEAD_BEEF_0000_0001);
      sr_q.push_back(64'hDEAD_BEEF_0000_0002);
      while (got_q.size() < b + 1 && cnt < 50) begin nedge(); cnt++; end
      spi_q.push_back(64'h5555_6666_7777_8888);
      while (got_q.size() < b + 4 && cnt < 100) begin nedge(); cnt++; end
      checks++; if (got_q[b] !== 8'hA2) begin errors++; $display("FAIL mreset_first_hdr got %h exp a2", got_q[b]); end
      step();
      res_n = 1'b0;
      step();
      res_n = 1'b1;
      b2 = got_q.size();
      nedge();
      checks++; if ({bus.tx_valid, bus.busy, bus.grant, bus.tx_data} !== 12'h000) begin errors++; $display("FAIL mreset_outputs got valid %b busy %b grant %b data %h exp 0", bus.tx_valid, bus.busy, bus.grant, bus.tx_data); end
      checks++; if ({bus.spi_fifo_rd_en, bus.sr_fifo_rd_en} !== 2'b10) begin errors++; $display("FAIL mreset_next_src got spi/sr rd_en %b exp 10", {bus.spi_fifo_rd_en, bus.sr_fifo_rd_en}); end
      exp_q.delete();
      exp_frame(8'hA1, 64'h5555_6666_7777_8888);
      exp_frame(8'hA2, 64'hDEAD_BEEF_0000_0002);
      cnt = 0;
      while (got_q.size() < b2 + 2 * FB && cnt < 300) begin nedge(); cnt++; end
      repeat (5) nedge();
      checks++; if (got_q.size() - b2 !== 2 * FB) begin errors++; $display("FAIL mreset_len got %0d exp %0d", got_q.size() - b2, 2 * FB); end
      for (int i = 0; i < 2 * FB; i++) begin
         checks++;
         if (got_q[b2+i] !== exp_q[i]) begin errors++; $display("FAIL mreset_byte %0d got %h exp %h", i, got_q[b2+i], exp_q[i]); end
      end
      checks++; if (sr_rd - r0 !== 2) begin errors++; $display("FAIL mreset_sr_pops got %0d exp 2", sr_rd - r0); end
      checks++; if (spi_rd - s0 !== 1) begin errors++; $display("FAIL mreset_spi_pops got %0d exp 1", spi_rd - s0); end
   endtask

   // arb_en dropped mid-frame: frame completes, no new pops until re-enabled
   task automatic test_arb_en();
      int b = got_q.size();
      int s0 = spi_rd;
      int r0 = sr_rd;
      int p0;
      int cnt = 0;
      bus.tx_ready = 1'b1;
      bus.arb_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         spi_q.push_back(64'hA0A0_0000_0000_0000 + 64'(i));
         sr_q.push_back(64'hB0B0_0000_0000_0000 + 64'(i));
      end
      while (got_q.size() < b + 3 && cnt < 50) begin nedge(); cnt++; end
      step();
      bus.arb_en = 1'b0;
      p0 = pop_src_q.size();
      cnt = 0;
      while (got_q.size() < b + FB && cnt < 100) begin nedge(); cnt++; end
      repeat (8) nedge();
      checks++; if (got_q.size() - b !== FB) begin errors++; $display("FAIL arben_frame_len got %0d exp %0d", got_q.size() - b, FB); end
      checks++; if (pop_src_q.size() - p0 !== 0) begin errors++; $display("FAIL arben_pops_low got %0d exp 0", pop_src_q.size() - p0); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL arben_busy_low got %b exp 0", bus.busy); end
      step();
      bus.arb_en = 1'b1;
      cnt = 0;
      while (got_q.size() < b + 6 * FB && cnt < 500) begin nedge(); cnt++; end
      repeat (3) nedge();
      checks++; if (got_q.size() - b !== 6 * FB) begin errors++; $display("FAIL arben_resume_len got %0d exp %0d", got_q.size() - b, 6 * FB); end
      checks++; if ((spi_rd - s0 !== 3) || (sr_rd - r0 !== 3)) begin errors++; $display("FAIL arben_pops got spi %0d sr %0d exp 3 3", spi_rd - s0, sr_rd - r0); end
   endtask

   // Zero word from SR: trailer byte present only in the trailer build
   task automatic test_trailer();
      int b = got_q.size();
      int cnt = 0;
      bus.tx_ready = 1'b1;
      bus.arb_en = 1'b1;
      sr_q.push_back(64'h0);
      while (got_q.size() < b + FB && cnt < 100) begin nedge(); cnt++; end
      repeat (5) nedge();
      checks++; if (got_q.size() - b !== FB) begin errors++; $display("FAIL trailer_len got %0d exp %0d", got_q.size() - b, FB); end
      for (int i = 0; i < FB; i++) begin
         checks++;
         if (got_q[b+i] !== e0[i]) begin errors++; $display("FAIL trailer_byte %0d got %h exp %h", i, got_q[b+i], e0[i]); end
      end
   endtask

   initial begin
      bus.arb_en = 1'b0;
      bus.tx_ready = 1'b0;
      res_n = 1'b0;
      test_reset();
      test_back_to_back();
      test_single();
      test_ready_toggle();
      test_mid_reset();
      test_arb_en();
      test_trailer();
      checks++; if (empty_pop_err !== 0) begin errors++; $display("FAIL pop_when_empty got %0d exp 0", empty_pop_err); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end

endmodule
